// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, DEPTH = 2**ADDR_W entries of DATA_W bits.
// NREAD combinational read ports, two clocked write ports (port 1 wins on a
// same-address collision), a per-register busy scoreboard and a commit counter.
// Register 0 always reads zero and is never busy.
// Optional macro RF_BYPASS_EN: forward same-cycle write data to the read ports.

// One read port: selects the stored word and busy bit for its address,
// with optional forwarding from the two write ports.
module regfile_mp_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] mem,
  input  logic [DEPTH-1:0]             busy,
  input  logic                         wen0,
  input  logic [ADDR_W-1:0]            waddr0,
  input  logic [DATA_W-1:0]            wdata0,
  input  logic                         wen1,
  input  logic [ADDR_W-1:0]            waddr1,
  input  logic [DATA_W-1:0]            wdata1,
  input  logic                         issue_en,
  input  logic [ADDR_W-1:0]            issue_addr,
  output logic [DATA_W-1:0]            data,
  output logic                         busy_o
);

`ifdef RF_BYPASS_EN
  // Read mux with forwarding; port 1 is checked first so it wins collisions.
  always_comb begin
    data   = '0;
    busy_o = 1'b0;
    if (rst_n && addr != '0) begin
      data   = mem[addr];
      busy_o = busy[addr];
      if (wen1 && waddr1 == addr) begin
        data   = wdata1;
        busy_o = issue_en && (issue_addr == addr);
      end else if (wen0 && waddr0 == addr) begin
        data   = wdata0;
        busy_o = issue_en && (issue_addr == addr);
      end
    end
  end
`else
  // Write and issue inputs only matter when forwarding is built in.
  logic unused_fwd;
  assign unused_fwd = ^{wen0, waddr0, wdata0, wen1, waddr1, wdata1, issue_en, issue_addr};

  // Read mux from stored contents only; zero while reset is held or for r0.
  always_comb begin
    data   = '0;
    busy_o = 1'b0;
    if (rst_n && addr != '0) begin
      data   = mem[addr];
      busy_o = busy[addr];
    end
  end
`endif

endmodule

module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int CNT_W  = 32
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [NREAD*ADDR_W-1:0] RAddr,
  output logic [NREAD*DATA_W-1:0] RData,
  output logic [NREAD-1:0]        RBusy,
  input  logic                    WEn0,
  input  logic [ADDR_W-1:0]       WAddr0,
  input  logic [DATA_W-1:0]       WData0,
  input  logic                    WEn1,
  input  logic [ADDR_W-1:0]       WAddr1,
  input  logic [DATA_W-1:0]       WData1,
  input  logic                    IssueEn,
  input  logic [ADDR_W-1:0]       IssueAddr,
  output logic [CNT_W-1:0]        CommitCnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  // Qualified write enables: r0 writes are discarded, and port 0 is dropped
  // when port 1 targets the same register.
  logic w0_nz, w1_nz, w0_eff;
  assign w0_nz  = WEn0 && (WAddr0 != '0);
  assign w1_nz  = WEn1 && (WAddr1 != '0);
  assign w0_eff = w0_nz && !(w1_nz && (WAddr0 == WAddr1));

  // Storage update; r0 stays at its reset value forever.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_q <= '0;
    end else begin
      if (w0_eff) mem_q[WAddr0] <= WData0;
      if (w1_nz)  mem_q[WAddr1] <= WData1;
    end
  end

  // Scoreboard next state: writeback clears, issue sets, and set wins.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < DEPTH; i++) begin
      if ((w0_nz && WAddr0 == ADDR_W'(i)) || (w1_nz && WAddr1 == ADDR_W'(i)))
        busy_d[i] = 1'b0;
      if (IssueEn && IssueAddr == ADDR_W'(i))
        busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Commit count advances by the number of distinct registers written.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(w0_eff) + CNT_W'(w1_nz);
  end

  // Scoreboard and counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign CommitCnt = cnt_q;

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_rd (
      .rst_n      (Reset_n),
      .addr       (RAddr[p*ADDR_W +: ADDR_W]),
      .mem        (mem_q),
      .busy       (busy_q),
      .wen0       (w0_nz),
      .waddr0     (WAddr0),
      .wdata0     (WData0),
      .wen1       (w1_nz),
      .waddr1     (WAddr1),
      .wdata1     (WData1),
      .issue_en   (IssueEn),
      .issue_addr (IssueAddr),
      .data       (RData[p*DATA_W +: DATA_W]),
      .busy_o     (RBusy[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors with literal expectations, plus a
// behavioural array model compared against the DUT on every falling edge.
// A second instance with a 4-bit commit counter exercises wrap-around.
module tb_regfile_mp;

  logic        Clk, Reset_n;
  logic [4:0]  ra0, ra1;
  logic [9:0]  RAddr;
  logic [63:0] RData, RData4;
  logic [1:0]  RBusy, RBusy4;
  logic        WEn0, WEn1, IssueEn;
  logic [4:0]  WAddr0, WAddr1, IssueAddr;
  logic [31:0] WData0, WData1;
  logic [31:0] CommitCnt;
  logic [3:0]  CommitCnt4;

  int errors = 0;
  int checks = 0;

  assign RAddr = {ra1, ra0};

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .CNT_W(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .RAddr(RAddr), .RData(RData), .RBusy(RBusy),
    .WEn0(WEn0), .WAddr0(WAddr0), .WData0(WData0),
    .WEn1(WEn1), .WAddr1(WAddr1), .WData1(WData1),
    .IssueEn(IssueEn), .IssueAddr(IssueAddr), .CommitCnt(CommitCnt)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .CNT_W(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .RAddr(RAddr), .RData(RData4), .RBusy(RBusy4),
    .WEn0(WEn0), .WAddr0(WAddr0), .WData0(WData0),
    .WEn1(WEn1), .WAddr1(WAddr1), .WData1(WData1),
    .IssueEn(IssueEn), .IssueAddr(IssueAddr), .CommitCnt(CommitCnt4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0]   m_mem [32];
  bit          m_busy[32];
  int unsigned m_cnt;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  <= '0;
        m_busy[i] <= 1'b0;
      end
      m_cnt <= 0;
    end else begin
      int written[$];
      written = {};
      // Port 0 applied first, port 1 second so port 1 overwrites on collision.
      if (WEn0 && WAddr0 != 0) begin
        m_mem[WAddr0]  <= WData0;
        m_busy[WAddr0] <= 1'b0;
        written.push_back(int'(WAddr0));
      end
      if (WEn1 && WAddr1 != 0) begin
        m_mem[WAddr1]  <= WData1;
        m_busy[WAddr1] <= 1'b0;
        if (written.size() == 0 || written[0] != int'(WAddr1))
          written.push_back(int'(WAddr1));
      end
      if (IssueEn && IssueAddr != 0) m_busy[IssueAddr] <= 1'b1;
      m_cnt <= m_cnt + written.size();
    end
  end

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (!Reset_n || a == 0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (WEn1 && WAddr1 == a) return WData1;
    if (WEn0 && WAddr0 == a) return WData0;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!Reset_n || a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if ((WEn1 && WAddr1 == a) || (WEn0 && WAddr0 == a))
      return IssueEn && IssueAddr == a;
`endif
    return m_busy[a];
  endfunction

  // Every falling edge: outputs against the model.
  always @(negedge Clk) begin
    chk("m_rdata0", RData[31:0],  exp_data(ra0));
    chk("m_rdata1", RData[63:32], exp_data(ra1));
    chk("m_rbusy0", {31'b0, RBusy[0]}, {31'b0, exp_busy(ra0)});
    chk("m_rbusy1", {31'b0, RBusy[1]}, {31'b0, exp_busy(ra1)});
    chk("m_cnt",    CommitCnt, m_cnt);
    chk("m_cnt4",   {28'b0, CommitCnt4}, m_cnt & 32'hF);
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    WEn0 = 0; WEn1 = 0; IssueEn = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    WEn0 = 1; WAddr0 = a; WData0 = d;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    WEn1 = 1; WAddr1 = a; WData1 = d;
  endtask

  initial begin
    Reset_n = 0;
    ra0 = 0; ra1 = 0;
    WAddr0 = 0; WAddr1 = 0; WData0 = 0; WData1 = 0; IssueAddr = 0;
    idle();
    tick(); tick();
    chk("rst_cnt", CommitCnt, 32'h0);
    chk("rst_rdata", RData[31:0], 32'h0);
    Reset_n = 1;

    // Write r5, then assert reset mid-cycle: outputs clear with no edge.
    wr0(5'd5, 32'hDEADBEEF); ra0 = 5'd5;
    tick(); idle();
    chk("r5_written", RData[31:0], 32'hDEADBEEF);
    chk("cnt_after_r5", CommitCnt, 32'd1);
    IssueEn = 1; IssueAddr = 5'd5;
    tick(); idle();
    chk("r5_busy", {31'b0, RBusy[0]}, 32'd1);
    #1 Reset_n = 0;
    #1;
    chk("async_rst_rdata", RData[31:0], 32'h0);
    chk("async_rst_cnt", CommitCnt, 32'h0);
    chk("async_rst_busy", {30'b0, RBusy}, 32'h0);
    tick();
    Reset_n = 1;

    // Same-address collision: port 1 stored, counts once.
    wr0(5'd3, 32'h11111111); wr1(5'd3, 32'h22222222); ra0 = 5'd3;
    tick(); idle();
    chk("collide_data", RData[31:0], 32'h22222222);
    chk("collide_cnt", CommitCnt, 32'd1);

    // r0 write and issue are ignored.
    wr0(5'd0, 32'hFFFFFFFF); IssueEn = 1; IssueAddr = 5'd0; ra0 = 5'd0;
    tick(); idle();
    chk("r0_data", RData[31:0], 32'h0);
    chk("r0_busy", {31'b0, RBusy[0]}, 32'd0);
    chk("r0_cnt", CommitCnt, 32'd1);

    // Scoreboard: issue sets, set beats same-cycle clear, lone write clears.
    IssueEn = 1; IssueAddr = 5'd7; ra0 = 5'd7;
    #1 chk("r7_busy_pre", {31'b0, RBusy[0]}, 32'd0);
    tick(); idle();
    chk("r7_busy_set", {31'b0, RBusy[0]}, 32'd1);
    wr1(5'd7, 32'h5A5A5A5A); IssueEn = 1; IssueAddr = 5'd7;
    tick(); idle();
    chk("r7_data", RData[31:0], 32'h5A5A5A5A);
    chk("r7_busy_held", {31'b0, RBusy[0]}, 32'd1);
    chk("r7_cnt", CommitCnt, 32'd2);
    wr0(5'd7, 32'h1);
    tick(); idle();
    chk("r7_busy_clr", {31'b0, RBusy[0]}, 32'd0);
    chk("r7_data1", RData[31:0], 32'h1);

    // Read-during-write on port 1.
    ra1 = 5'd9; wr0(5'd9, 32'hCAFEF00D);
    #1;
`ifdef RF_BYPASS_EN
    chk("rdw_same", RData[63:32], 32'hCAFEF00D);
`else
    chk("rdw_same", RData[63:32], 32'h0);
`endif
    tick(); idle();
    chk("rdw_next", RData[63:32], 32'hCAFEF00D);
    chk("rdw_cnt", CommitCnt, 32'd4);

    // Counter wrap on the 4-bit instance.
    Reset_n = 0;
    tick();
    Reset_n = 1;
    for (int i = 1; i <= 15; i++) begin
      wr0(5'(i), 32'(i * 3));
      tick();
    end
    idle();
    chk("wrap_15", {28'b0, CommitCnt4}, 32'd15);
    wr0(5'd1, 32'hA1); wr1(5'd2, 32'hB2); ra0 = 5'd1; ra1 = 5'd2;
    tick(); idle();
    chk("wrap_1", {28'b0, CommitCnt4}, 32'd1);
    chk("wide_17", CommitCnt, 32'd17);
    chk("dual_r1", RData[31:0], 32'hA1);
    chk("dual_r2", RData[63:32], 32'hB2);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined datapath: DEPTH x DATA_W storage, NREAD combinational read ports, two clocked write ports.
- Adds a per-register busy scoreboard (set at issue, cleared at writeback) and a commit counter. Hazard logic uses these to stall.
- Register 0 is hard-wired zero.
- Sits between decode (read/issue) and writeback (write ports).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NREAD, 2, number of read ports (1..4)
- CNT_W, 32, commit counter width

Ports:
- Clk  input  1  clock, rising edge active
- Reset_n  input  1  asynchronous, active-low reset
- RAddr  input  NREAD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- RData  output  NREAD*DATA_W  packed read data, combinational
- RBusy  output  NREAD  busy flag of the register addressed by each read port
- WEn0  input  1  write port 0 enable
- WAddr0  input  ADDR_W  write port 0 address
- WData0  input  DATA_W  write port 0 data
- WEn1  input  1  write port 1 enable (priority port)
- WAddr1  input  ADDR_W  write port 1 address
- WData1  input  DATA_W  write port 1 data
- IssueEn  input  1  mark IssueAddr busy (pending producer)
- IssueAddr  input  ADDR_W  destination being issued
- CommitCnt  output  CNT_W  number of committed register writes

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - all registers := 0
  - all busy bits := 0
  - CommitCnt := 0
  - RData reads 0 while reset is held; RBusy = 0
- Reads:
  - combinational
  - address 0 -> 0, RBusy = 0
  - otherwise RData = stored value, RBusy = busy[addr]
- Writes:
  - take effect on the rising Clk edge
  - a write to address 0 is discarded
  - WEn0 and WEn1 to the same non-zero address in one cycle: port 1 data is stored, port 0 is dropped
- Busy bits, per non-zero address, evaluated at the rising edge:
  - issue-set: IssueEn && IssueAddr==a -> busy[a] := 1
  - write-clear: (WEn0 && WAddr0==a) || (WEn1 && WAddr1==a) -> busy[a] := 0
  - issue-set and write-clear in the same cycle: set wins (new producer supersedes the retiring one)
  - neither: hold
  - IssueAddr 0 is ignored
- CommitCnt, at the rising edge:
  - increments by the number of distinct non-zero addresses written that cycle (0, 1 or 2)
  - a same-address collision counts as 1
  - wraps modulo 2**CNT_W
- Read-during-write (same address, same cycle, feature off): RData returns the old value; the new value is visible the next cycle.
- Reset deasserted mid-operation: the first rising edge after deassertion performs normal writes and issues.
- Latency:
  - read: 0 cycles
  - write: visible 1 cycle after the edge
  - busy: visible 1 cycle after the edge

Optional Feature:
- Macro: RF_BYPASS_EN
- Defined:
  - a read whose address matches an enabled non-zero write in the current cycle returns that write data combinationally
  - port 1 has priority on collision
  - RBusy for that address is 0 unless IssueEn also targets it this cycle
  - storage timing is unchanged
- Undefined:
  - no forwarding; reads return stored contents only
  - RBusy reflects the registered busy bits only

Test Plan:
- Reset_n=0 mid-run after writing r5=0xDEADBEEF -> RData(r5)=0, CommitCnt=0, RBusy=0 immediately, without waiting for a clock edge.
- WEn0 r3=0x11111111, WEn1 r3=0x22222222, same edge -> r3 reads 0x22222222 next cycle; CommitCnt += 1.
- WEn0 r0=0xFFFFFFFF, IssueEn r0 -> RData(r0)=0, RBusy=0, CommitCnt unchanged.
- IssueEn r7 at cycle N -> RBusy(r7)=1 from N+1.
  - Then WEn1 r7=0x5A5A5A5A with IssueEn r7 in the same cycle -> r7=0x5A5A5A5A, RBusy stays 1.
  - Then WEn0 r7=0x1 alone -> RBusy(r7)=0.
- Read r9 while WEn0 r9=0xCAFEF00D (old value 0x0):
  - without RF_BYPASS_EN -> RData=0x0 this cycle, 0xCAFEF00D next cycle
  - with RF_BYPASS_EN -> RData=0xCAFEF00D this cycle
- CNT_W=4: 15 single writes, then one cycle writing r1 and r2 on both ports -> CommitCnt=15, then wraps to 1.
